// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared definitions for the fetch-address generator.
//   - redirect op encodings carried on the 3-bit op bus
//   - FSM state type for pc_gen
//   - instruction size in bytes
package pc_gen_pkg;

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_J    = 3'd2;
    localparam logic [2:0] OP_JR   = 3'd3;
    localparam logic [2:0] OP_EXC  = 3'd4;
    localparam logic [2:0] OP_ERET = 3'd5;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_t;

    localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/pc_gen_npc_target.sv
// npc_target: combinational redirect-target computation and alignment check.
// Ports:
//   i_op        redirect kind (pc_gen_pkg OP_* encodings)
//   i_base_pc   PC of the redirecting instruction
//   i_imm       signed branch word offset
//   i_jidx      jump index field
//   i_reg_tgt   register value for JR
//   i_epc       return address for ERET
//   o_raw       target before the alignment trap is applied
//   o_misalign  JR/ERET target is not word-aligned
//   o_target    target actually used (EXC_VEC when misaligned)
module npc_target
    import pc_gen_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(32'h0000_4180)
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_base_pc,
    input  logic [15:0]      i_imm,
    input  logic [25:0]      i_jidx,
    input  logic [WIDTH-1:0] i_reg_tgt,
    input  logic [WIDTH-1:0] i_epc,
    output logic [WIDTH-1:0] o_raw,
    output logic             o_misalign,
    output logic [WIDTH-1:0] o_target
);

    logic [WIDTH-1:0] w_seq4;
    logic [WIDTH-1:0] w_br_off;

    assign w_seq4   = i_base_pc + WIDTH'(INSN_BYTES);
    // Sign-extended word offset converted to bytes.
    assign w_br_off = {{(WIDTH-18){i_imm[15]}}, i_imm, 2'b00};

    always_comb begin
        o_raw = '0;
        case (i_op)
            OP_BR:   o_raw = w_seq4 + w_br_off;
            OP_J:    o_raw = {w_seq4[WIDTH-1:28], i_jidx, 2'b00};
            OP_JR:   o_raw = i_reg_tgt;
            OP_EXC:  o_raw = EXC_VEC;
            OP_ERET: o_raw = i_epc;
            default: o_raw = '0;
        endcase
    end

    assign o_misalign = ((i_op == OP_JR) || (i_op == OP_ERET)) && (o_raw[1:0] != 2'b00);
    assign o_target   = o_misalign ? EXC_VEC : o_raw;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: sequential fetch-address generator holding the architectural PC.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   op, op_valid      redirect request (SEQ/BR/J/JR/EXC/ERET)
//   base_pc, imm,     target operands for branches and jumps
//   jidx, reg_tgt,
//   epc
//   stall             pipeline stall, blocks PC advance
//   fetch_ready       instruction memory accepts fetch_pc
//   fetch_valid       fetch_pc is a valid request (registered)
//   fetch_pc          current PC register
//   addr_err          one-cycle pulse after a misaligned target is trapped
//   bad_addr          last misaligned target
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_4180)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] base_pc,
    input  logic [15:0]      imm,
    input  logic [25:0]      jidx,
    input  logic [WIDTH-1:0] reg_tgt,
    input  logic [WIDTH-1:0] epc,
    input  logic             stall,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_pc,
    output logic             addr_err,
    output logic [WIDTH-1:0] bad_addr
);

    pc_state_t        r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pend;
    logic             r_err;
    logic [WIDTH-1:0] r_bad;

    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_tgt;
    logic             w_mis;
    logic             w_adv;
    logic             w_exc;
    logic             w_brc;

    pc_state_t        w_nstate;
    logic [WIDTH-1:0] w_npc;
    logic [WIDTH-1:0] w_npend;
    logic             w_trap;

    npc_target #(
        .WIDTH   (WIDTH),
        .EXC_VEC (EXC_VEC)
    ) u_npc_target (
        .i_op       (op),
        .i_base_pc  (base_pc),
        .i_imm      (imm),
        .i_jidx     (jidx),
        .i_reg_tgt  (reg_tgt),
        .i_epc      (epc),
        .o_raw      (w_raw),
        .o_misalign (w_mis),
        .o_target   (w_tgt)
    );

    assign w_adv = r_valid & fetch_ready & ~stall;
    assign w_exc = op_valid & ((op == OP_EXC) | (op == OP_ERET));
    assign w_brc = op_valid & ((op == OP_BR) | (op == OP_J) | (op == OP_JR));

    always_comb begin
        w_nstate = r_state;
        w_npc    = r_pc;
        w_npend  = r_pend;
        w_trap   = 1'b0;
        case (r_state)
            BOOT: begin
                w_nstate = RUN;
            end
            RUN: begin
                if (w_exc) begin
                    w_npc  = w_tgt;
                    w_trap = w_mis;
                end else if (w_brc) begin
                    // A misaligned JR is trapped when issued, even if deferred.
                    w_trap = w_mis;
                    if (w_adv) begin
                        w_npc = w_tgt;
                    end else begin
                        w_npend  = w_tgt;
                        w_nstate = HOLD;
                    end
                end else if (w_adv) begin
                    w_npc = r_pc + WIDTH'(INSN_BYTES);
                end
            end
            HOLD: begin
                // Branch-class ops here are illegal double redirects and ignored.
                if (w_exc) begin
                    w_npc    = w_tgt;
                    w_npend  = '0;
                    w_nstate = RUN;
                    w_trap   = w_mis;
                end else if (w_adv) begin
                    w_npc    = r_pend;
                    w_npend  = '0;
                    w_nstate = RUN;
                end
            end
            default: begin
                w_nstate = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_pend  <= '0;
            r_err   <= 1'b0;
            r_bad   <= '0;
        end else begin
            r_state <= w_nstate;
            r_valid <= (w_nstate != BOOT);
            r_pc    <= w_npc;
            r_pend  <= w_npend;
            r_err   <= w_trap;
            if (w_trap) begin
                r_bad <= w_raw;
            end
        end
    end

    assign fetch_valid = r_valid;
    assign fetch_pc    = r_pc;
    assign addr_err    = r_err;
    assign bad_addr    = r_bad;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EV     = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        op_valid = 1'b0;
    logic [31:0] base_pc = '0;
    logic [15:0] imm = '0;
    logic [25:0] jidx = '0;
    logic [31:0] reg_tgt = '0;
    logic [31:0] epc = '0;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        addr_err;
    logic [31:0] bad_addr;

    pc_gen #(
        .WIDTH    (32),
        .RESET_PC (RST_PC),
        .EXC_VEC  (EV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .op_valid    (op_valid),
        .base_pc     (base_pc),
        .imm         (imm),
        .jidx        (jidx),
        .reg_tgt     (reg_tgt),
        .epc         (epc),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .addr_err    (addr_err),
        .bad_addr    (bad_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ov;
        logic [2:0]  op;
        logic [31:0] base;
        logic [15:0] imm;
        logic [25:0] jidx;
        logic [31:0] rt;
        logic [31:0] ep;
        bit          rdy;
        bit          st;
    } stim_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        err;
        logic [31:0] bad;
    } exp_t;

    exp_t q[$];

    // Reference model state
    bit          m_boot;
    bit          m_v;
    logic [31:0] m_pc;
    bit          m_err;
    logic [31:0] m_bad;
    logic [31:0] m_pend[$];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.ov = 1'b0; s.op = 3'd0; s.base = '0; s.imm = '0; s.jidx = '0;
        s.rt = '0; s.ep = '0; s.rdy = 1'b1; s.st = 1'b0;
        return s;
    endfunction

    function automatic logic [31:0] raw_target(input int k, input stim_t s);
        int off;
        case (k)
            1: begin
                off = int'($signed(s.imm));
                return s.base + 32'd4 + 32'(off * 4);
            end
            2: return ((s.base + 32'd4) & 32'hF000_0000) | (32'(s.jidx) * 32'd4);
            3: return s.rt;
            4: return EV;
            5: return s.ep;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_boot = 1'b1; m_v = 1'b0; m_pc = RST_PC; m_err = 1'b0; m_bad = '0;
        m_pend.delete();
    endtask

    task automatic model_step(input stim_t s);
        int          k;
        logic [31:0] raw, t;
        bit          mis, adv, e;
        exp_t        x;
        if (m_boot) begin
            m_boot = 1'b0;
            m_v    = 1'b1;
            m_err  = 1'b0;
        end else begin
            k = s.ov ? int'(s.op) : 0;
            if (k > 5) k = 0;
            raw = raw_target(k, s);
            mis = (k == 3 || k == 5) && (raw % 4 != 0);
            t   = mis ? EV : raw;
            adv = m_v && s.rdy && !s.st;
            e   = 1'b0;
            if (k == 4 || k == 5) begin
                m_pc = t;
                m_pend.delete();
                e = mis;
            end else if (m_pend.size() > 0) begin
                if (adv) m_pc = m_pend.pop_front();
            end else if (k >= 1 && k <= 3) begin
                if (adv) m_pc = t;
                else m_pend.push_back(t);
                e = mis;
            end else if (adv) begin
                m_pc = m_pc + 32'd4;
            end
            m_err = e;
            if (e) m_bad = raw;
        end
        x.v = m_v; x.pc = m_pc; x.err = m_err; x.bad = m_bad;
        q.push_back(x);
    endtask

    task automatic drive(input stim_t s);
        op_valid = s.ov; op = s.op; base_pc = s.base; imm = s.imm; jidx = s.jidx;
        reg_tgt = s.rt; epc = s.ep; fetch_ready = s.rdy; stall = s.st;
        model_step(s);
    endtask

    task automatic cyc(input stim_t s);
        @(negedge clk);
        drive(s);
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, releases it.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_pc", fetch_pc, RST_PC);
        chk("rst_err", 32'(addr_err), 32'd0);
        chk("rst_bad", bad_addr, 32'd0);
        q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(idle());
    endtask

    // Monitor: pops one expectation per clock once the driver has pushed it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("fetch_valid", 32'(fetch_valid), 32'(e.v));
                if (e.v) chk("fetch_pc", fetch_pc, e.pc);
                chk("addr_err", 32'(addr_err), 32'(e.err));
                chk("bad_addr", bad_addr, e.bad);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        stim_t s;
        model_reset();
        do_reset();
        repeat (3) cyc(idle());

        // BR backwards
        s = idle(); s.ov = 1; s.op = 3'd1; s.base = 32'h3010; s.imm = 16'hFFFC; cyc(s);
        // J
        s = idle(); s.ov = 1; s.op = 3'd2; s.base = 32'h3000; s.jidx = 26'h0000C40; cyc(s);
        // Deferred BR, second BR in HOLD ignored
        s = idle(); s.ov = 1; s.op = 3'd1; s.base = 32'h3100; s.imm = 16'h0004; s.rdy = 0; cyc(s);
        s.imm = 16'h0008; cyc(s);
        s = idle(); s.rdy = 0; cyc(s);
        cyc(idle());
        cyc(idle());
        // EXC with stall and no ready
        s = idle(); s.ov = 1; s.op = 3'd4; s.st = 1; s.rdy = 0; cyc(s);
        // ERET in HOLD discards pending
        s = idle(); s.ov = 1; s.op = 3'd1; s.base = 32'h5000; s.rdy = 0; cyc(s);
        s = idle(); s.ov = 1; s.op = 3'd5; s.ep = 32'h3020; s.rdy = 0; cyc(s);
        cyc(idle());
        cyc(idle());
        // Misaligned JR traps
        s = idle(); s.ov = 1; s.op = 3'd3; s.rt = 32'h3006; cyc(s);
        cyc(idle());
        cyc(idle());
        // Wrap from the top of the address space
        s = idle(); s.ov = 1; s.op = 3'd3; s.rt = 32'hFFFF_FFFC; cyc(s);
        cyc(idle());
        cyc(idle());
        // Reset while in HOLD drops the pending branch
        s = idle(); s.ov = 1; s.op = 3'd1; s.base = 32'h7000; s.rdy = 0; cyc(s);
        cyc(s);
        do_reset();
        repeat (4) cyc(idle());

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                s.ov   = ($urandom_range(0, 1) == 1);
                s.op   = 3'($urandom_range(0, 7));
                s.base = $urandom() & 32'hFFFF_FFFC;
                s.imm  = 16'($urandom());
                s.jidx = 26'($urandom());
                s.rt   = $urandom();
                s.ep   = $urandom();
                if ($urandom_range(0, 3) != 0) begin
                    s.rt[1:0] = 2'b00;
                    s.ep[1:0] = 2'b00;
                end
                s.rdy = ($urandom_range(0, 3) != 0);
                s.st  = ($urandom_range(0, 4) == 0);
                cyc(s);
            end
        end

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
